// File: rtl/nco_phase_gen_8ch.sv
// Eight-channel NCO phase generator: one shared phase accumulator with a
// sample-rate divider, per-channel phase offsets and double-buffered config.
module nco_phase_gen_8ch #(
  parameter int ACC_WIDTH  = 24,
  parameter int ADDR_WIDTH = 9,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_run,
  input  logic                  i_sync,
  input  logic                  i_wr_en,
  input  logic [3:0]            i_wr_sel,
  input  logic [ACC_WIDTH-1:0]  i_wr_data,
  output logic [ADDR_WIDTH-1:0] o_addr_a,
  output logic [ADDR_WIDTH-1:0] o_addr_b,
  output logic [ADDR_WIDTH-1:0] o_addr_c,
  output logic [ADDR_WIDTH-1:0] o_addr_d,
  output logic [ADDR_WIDTH-1:0] o_addr_e,
  output logic [ADDR_WIDTH-1:0] o_addr_f,
  output logic [ADDR_WIDTH-1:0] o_addr_g,
  output logic [ADDR_WIDTH-1:0] o_addr_h,
  output logic                  o_en,
  output logic                  o_wrap
);

  localparam int NCH = 8;

  logic [ACC_WIDTH-1:0]  ftw_sh_q, ftw_sh_d, ftw_act_q, ftw_act_d;
  logic [DIV_WIDTH-1:0]  div_sh_q, div_sh_d, div_act_q, div_act_d;
  logic [ADDR_WIDTH-1:0] off_sh_q [NCH];
  logic [ADDR_WIDTH-1:0] off_sh_d [NCH];
  logic [ADDR_WIDTH-1:0] off_act_q[NCH];
  logic [ADDR_WIDTH-1:0] off_act_d[NCH];
  logic [ADDR_WIDTH-1:0] addr_q   [NCH];
  logic [ADDR_WIDTH-1:0] addr_d   [NCH];
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  en_q, en_d, wrap_q, wrap_d;

  logic                  tick, carry, commit;
  logic [ACC_WIDTH:0]    sum;
  logic [ADDR_WIDTH-1:0] phase_addr;

  always_comb begin
    tick       = i_run && !i_sync && (cnt_q == div_act_q);
    sum        = {1'b0, acc_q} + {1'b0, ftw_act_q};
    carry      = sum[ACC_WIDTH];
    phase_addr = sum[ACC_WIDTH-1 -: ADDR_WIDTH];
    // Commit only at a phase wrap (or while idle) so a new FTW/DIV/offset set
    // never takes effect mid-period.
    commit     = !i_run || (tick && carry);
  end

  always_comb begin
    ftw_sh_d = ftw_sh_q;
    div_sh_d = div_sh_q;
    off_sh_d = off_sh_q;
    if (i_wr_en) begin
      if (i_wr_sel == 4'd0) begin
        ftw_sh_d = i_wr_data;
      end else if (i_wr_sel == 4'd1) begin
        div_sh_d = i_wr_data[DIV_WIDTH-1:0];
      end else if (i_wr_sel[3]) begin
        off_sh_d[i_wr_sel[2:0]] = i_wr_data[ADDR_WIDTH-1:0];
      end
    end
  end

  // The active set copies the pre-edge shadow, so a write landing on a commit
  // edge waits for the following commit.
  always_comb begin
    ftw_act_d = ftw_act_q;
    div_act_d = div_act_q;
    off_act_d = off_act_q;
    if (commit) begin
      ftw_act_d = ftw_sh_q;
      div_act_d = div_sh_q;
      off_act_d = off_sh_q;
    end
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    en_d   = 1'b0;
    wrap_d = 1'b0;
    if (!i_run) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d  = '0;
      acc_d  = sum[ACC_WIDTH-1:0];
      wrap_d = carry;
      en_d   = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        addr_d[i] = phase_addr + off_act_q[i];
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (i_sync) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ftw_sh_q  <= '0;
      ftw_act_q <= '0;
      div_sh_q  <= '0;
      div_act_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      wrap_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        off_sh_q[i]  <= '0;
        off_act_q[i] <= '0;
        addr_q[i]    <= '0;
      end
    end else begin
      ftw_sh_q  <= ftw_sh_d;
      ftw_act_q <= ftw_act_d;
      div_sh_q  <= div_sh_d;
      div_act_q <= div_act_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      wrap_q    <= wrap_d;
      for (int i = 0; i < NCH; i++) begin
        off_sh_q[i]  <= off_sh_d[i];
        off_act_q[i] <= off_act_d[i];
        addr_q[i]    <= addr_d[i];
      end
    end
  end

  assign o_addr_a = addr_q[0];
  assign o_addr_b = addr_q[1];
  assign o_addr_c = addr_q[2];
  assign o_addr_d = addr_q[3];
  assign o_addr_e = addr_q[4];
  assign o_addr_f = addr_q[5];
  assign o_addr_g = addr_q[6];
  assign o_addr_h = addr_q[7];
  assign o_en     = en_q;
  assign o_wrap   = wrap_q;

endmodule

// File: tb/tb_nco_phase_gen_8ch.sv
// Bench for nco_phase_gen_8ch: directed scenarios with fixed expectations plus
// a randomized run against an arithmetic reference model.
module tb_nco_phase_gen_8ch;

  localparam longint ACC_MOD  = 64'd1 << 24;
  localparam longint ADDR_MOD = 64'd1 << 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0, run = 1'b0, sync = 1'b0, wr_en = 1'b0;
  logic [3:0]  wr_sel = '0;
  logic [23:0] wr_data = '0;
  logic [8:0]  o_addr_a, o_addr_b, o_addr_c, o_addr_d;
  logic [8:0]  o_addr_e, o_addr_f, o_addr_g, o_addr_h;
  logic        o_en, o_wrap;

  int checks = 0;
  int errors = 0;

  // reference model state (plain integers)
  longint m_ftw_sh, m_ftw_a, m_div_sh, m_div_a, m_acc, m_cnt;
  longint m_off_sh[8], m_off_a[8], m_addr[8];
  bit     m_en, m_wrap;

  nco_phase_gen_8ch dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_sync(sync),
    .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_data(wr_data),
    .o_addr_a(o_addr_a), .o_addr_b(o_addr_b), .o_addr_c(o_addr_c),
    .o_addr_d(o_addr_d), .o_addr_e(o_addr_e), .o_addr_f(o_addr_f),
    .o_addr_g(o_addr_g), .o_addr_h(o_addr_h),
    .o_en(o_en), .o_wrap(o_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic model_edge();
    bit     tick;
    longint s;
    if (rst) begin
      m_ftw_sh = 0; m_ftw_a = 0; m_div_sh = 0; m_div_a = 0;
      m_acc = 0; m_cnt = 0; m_en = 0; m_wrap = 0;
      for (int i = 0; i < 8; i++) begin
        m_off_sh[i] = 0; m_off_a[i] = 0; m_addr[i] = 0;
      end
      return;
    end
    tick   = run && !sync && (m_cnt == m_div_a);
    s      = m_acc + m_ftw_a;
    m_en   = tick;
    m_wrap = tick && (s >= ACC_MOD);
    if (tick)
      for (int i = 0; i < 8; i++)
        m_addr[i] = ((s % ACC_MOD) / (ACC_MOD / ADDR_MOD) + m_off_a[i]) % ADDR_MOD;
    if (!run || m_wrap) begin
      m_ftw_a = m_ftw_sh; m_div_a = m_div_sh;
      for (int i = 0; i < 8; i++) m_off_a[i] = m_off_sh[i];
    end
    if (wr_en) begin
      if (wr_sel == 0) m_ftw_sh = wr_data;
      else if (wr_sel == 1) m_div_sh = wr_data % 256;
      else if (wr_sel >= 8) m_off_sh[wr_sel - 8] = wr_data % ADDR_MOD;
    end
    if (!run || sync || tick) m_cnt = 0;
    else m_cnt = m_cnt + 1;
    if (sync) m_acc = 0;
    else if (tick) m_acc = s % ACC_MOD;
  endtask

  function automatic logic [73:0] exp_vec();
    logic [73:0] v;
    v = {m_en, m_wrap, 72'd0};
    for (int i = 0; i < 8; i++) v[i*9 +: 9] = 9'(m_addr[i]);
    return v;
  endfunction

  function automatic logic [73:0] dut_vec();
    return {o_en, o_wrap, o_addr_h, o_addr_g, o_addr_f, o_addr_e,
            o_addr_d, o_addr_c, o_addr_b, o_addr_a};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; run = 0; sync = 0; wr_en = 0;
    step();
    rst = 0;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [23:0] data);
    wr_en = 1; wr_sel = sel; wr_data = data;
    step();
    wr_en = 0;
  endtask

  task automatic test_reset();
    rst = 1; run = 1; sync = 0; wr_en = 1; wr_sel = 4'd0; wr_data = 24'hFFFFFF;
    step();
    step();
    checks++;
    if (dut_vec() !== 74'd0) begin
      errors++;
      $display("FAIL reset_state got %h want 0", dut_vec());
    end
    rst = 0; run = 0; wr_en = 0;
    step();
    checks++;
    if (dut_vec() !== 74'd0) begin
      errors++;
      $display("FAIL reset_write_ignored got %h want 0", dut_vec());
    end
  endtask

  task automatic test_basic();
    do_reset();
    wr(4'd0, 24'h008000);
    wr(4'd9, 24'h000040);
    step();
    run = 1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (o_en !== 1'b1 || o_wrap !== 1'b0 || o_addr_a !== 9'(k) || o_addr_b !== 9'(k + 'h40)) begin
        errors++;
        $display("FAIL basic k=%0d got en=%b a=%h b=%h want en=1 a=%h b=%h",
                 k, o_en, o_addr_a, o_addr_b, 9'(k), 9'(k + 'h40));
      end
    end
    run = 0;
    step();
    step();
    checks++;
    if (o_en !== 1'b0 || o_addr_a !== 9'd6) begin
      errors++;
      $display("FAIL basic_hold got en=%b a=%h want en=0 a=006", o_en, o_addr_a);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] ea[4];
    logic       ew[4];
    ea = '{9'h100, 9'h000, 9'h100, 9'h000};
    ew = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    wr(4'd0, 24'h800000);
    step();
    run = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (o_addr_a !== ea[k] || o_wrap !== ew[k] || o_en !== 1'b1) begin
        errors++;
        $display("FAIL wrap k=%0d got a=%h wrap=%b en=%b want a=%h wrap=%b en=1",
                 k, o_addr_a, o_wrap, o_en, ea[k], ew[k]);
      end
    end
    run = 0;
  endtask

  task automatic test_divider();
    do_reset();
    wr(4'd1, 24'h000003);
    wr(4'd0, 24'h008000);
    step();
    run = 1;
    for (int c = 1; c <= 16; c++) begin
      step();
      checks++;
      if (o_en !== (c % 4 == 0) || (c % 4 == 0 && o_addr_a !== 9'(c / 4))) begin
        errors++;
        $display("FAIL divider c=%0d got en=%b a=%h want en=%b a=%h",
                 c, o_en, o_addr_a, (c % 4 == 0), 9'(c / 4));
      end
    end
    run = 0;
  endtask

  task automatic test_deferred_commit();
    logic [8:0] ea[6];
    logic       ew[6];
    ea = '{9'h080, 9'h100, 9'h180, 9'h000, 9'h001, 9'h002};
    ew = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    wr(4'd0, 24'h400000);
    step();
    run = 1;
    for (int k = 0; k < 6; k++) begin
      if (k == 1) begin
        wr_en = 1; wr_sel = 4'd0; wr_data = 24'h008000;
      end
      step();
      wr_en = 0;
      checks++;
      if (o_addr_a !== ea[k] || o_wrap !== ew[k]) begin
        errors++;
        $display("FAIL deferred k=%0d got a=%h wrap=%b want a=%h wrap=%b",
                 k, o_addr_a, o_wrap, ea[k], ew[k]);
      end
    end
    run = 0;
  endtask

  task automatic test_offset_mod();
    do_reset();
    wr(4'd8, 24'h0001FF);
    wr(4'd0, 24'h008000);
    step();
    run = 1;
    step();
    checks++;
    if (o_addr_a !== 9'h000) begin
      errors++;
      $display("FAIL offset_mod1 got %h want 000", o_addr_a);
    end
    step();
    checks++;
    if (o_addr_a !== 9'h001) begin
      errors++;
      $display("FAIL offset_mod2 got %h want 001", o_addr_a);
    end
    run = 0;
  endtask

  task automatic test_reset_sync();
    do_reset();
    wr(4'd0, 24'h008000);
    wr(4'd12, 24'h000033);
    step();
    run = 1;
    repeat (5) step();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (dut_vec() !== 74'd0) begin
      errors++;
      $display("FAIL reset_midrun got %h want 0", dut_vec());
    end
    run = 0;
    do_reset();
    wr(4'd1, 24'h000003);
    wr(4'd0, 24'h008000);
    step();
    run = 1;
    repeat (11) step();
    sync = 1;
    step();
    sync = 0;
    checks++;
    if (o_en !== 1'b0 || o_wrap !== 1'b0 || o_addr_a !== 9'd2) begin
      errors++;
      $display("FAIL sync_edge got en=%b wrap=%b a=%h want en=0 wrap=0 a=002",
               o_en, o_wrap, o_addr_a);
    end
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++;
      if (o_en !== (c == 4) || (c == 4 && o_addr_a !== 9'd1)) begin
        errors++;
        $display("FAIL sync_resume c=%0d got en=%b a=%h want en=%b a=001",
                 c, o_en, o_addr_a, (c == 4));
      end
    end
    run = 0;
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 127) == 0);
      run     = ($urandom_range(0, 15) != 0);
      sync    = ($urandom_range(0, 40) == 0);
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_sel  = 4'($urandom_range(0, 15));
      wr_data = (wr_sel == 4'd1) ? 24'($urandom_range(0, 4)) : 24'($urandom);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        if (bad < 10)
          $display("FAIL random n=%0d got %h want %h", n, dut_vec(), exp_vec());
        bad++;
      end
    end
    rst = 0; run = 0; sync = 0; wr_en = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_divider();
    test_deferred_commit();
    test_offset_mod();
    test_reset_sync();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
